aurora_link_sequencer: RTL and testbench



---
 rtl/aurora_link_sequencer_if.sv | 21 ++
 rtl/aurora_link_sequencer.sv | 104 ++++++++++
 tb/tb_aurora_link_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/aurora_link_sequencer_if.sv
// aurora_link_sequencer_if: control/status bundle between an Aurora core wrapper and its link sequencer
interface aurora_link_sequencer_if;
    logic        enable;
    logic        forceRestart;
    logic        channelUp;
    logic        pmaInit;
    logic        resetPb;
    logic        linkReady;
    logic [2:0]  state;
    logic [7:0]  retryCount;
    logic [15:0] dropCount;
    logic [31:0] upTime;
    modport master (
        input  enable, forceRestart, channelUp,
        output pmaInit, resetPb, linkReady, state, retryCount, dropCount, upTime
    );
    modport slave (
        output enable, forceRestart, channelUp,
        input  pmaInit, resetPb, linkReady, state, retryCount, dropCount, upTime
    );
endinterface

// File: rtl/aurora_link_sequencer.sv
// aurora_link_sequencer: Aurora pmaInit/resetPb bring-up, timeout retry and drop recovery; stats via AURORA_SEQ_STATS_EN
module aurora_link_sequencer #(
    parameter int PMA_INIT_CYCLES = 1024,
    parameter int RESET_PB_HOLD   = 128,
    parameter int LINK_TIMEOUT    = 12500000,
    parameter int DROP_FILTER     = 16,
    parameter int TIMER_WIDTH     = 24
) (
    input logic sysClk,
    input logic sysReset,
    aurora_link_sequencer_if.master link
);
    typedef enum logic [2:0] {IDLE = 3'd0, PMA = 3'd1, PB = 3'd2, WAIT = 3'd3, UP = 3'd4} state_t;
    localparam logic [TIMER_WIDTH-1:0] PMA_LD  = TIMER_WIDTH'(PMA_INIT_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] PB_LD   = TIMER_WIDTH'(RESET_PB_HOLD - 1);
    localparam logic [TIMER_WIDTH-1:0] WAIT_LD = TIMER_WIDTH'(LINK_TIMEOUT - 1);
    localparam logic [TIMER_WIDTH-1:0] DROP_N  = TIMER_WIDTH'(DROP_FILTER);
    state_t state_q, state_d;
    logic [1:0] sync_q;
    logic ch_up_s, expired, restart, timeout;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d, low_run_q, low_run_d, load_val;
    logic [7:0] retry_q, retry_d;
    logic pma_q, pb_q, ready_q;
    assign ch_up_s = sync_q[1];
    assign expired = timer_q == '0;
    always_comb begin
        state_d = state_q;
        restart = 1'b0;
        timeout = 1'b0;
        if (!link.enable)
            state_d = IDLE;
        else if (link.forceRestart && state_q != IDLE) begin
            state_d = PMA;
            restart = 1'b1;
        end else
            case (state_q)
                IDLE: state_d = PMA;
                PMA:  state_d = expired ? PB : PMA;
                PB:   state_d = expired ? WAIT : PB;
                WAIT: begin
                    // a channelUp arriving in the expiry cycle still wins over the retry
                    state_d = ch_up_s ? UP : expired ? PMA : WAIT;
                    timeout = !ch_up_s && expired;
                end
                UP:   state_d = low_run_q == DROP_N ? PMA : UP;
                default: state_d = IDLE;
            endcase
        load_val = state_d == PMA ? PMA_LD : state_d == PB ? PB_LD : state_d == WAIT ? WAIT_LD : '0;
        timer_d = (state_d != state_q || restart) ? load_val : expired ? timer_q : timer_q - 1'b1;
        low_run_d = (state_q == UP && state_d == UP && !ch_up_s) ? low_run_q + 1'b1 : '0;
        retry_d = (timeout && retry_q != 8'hFF) ? retry_q + 8'd1 : retry_q;
    end
    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            state_q   <= IDLE;
            sync_q    <= '0;
            timer_q   <= '0;
            low_run_q <= '0;
            retry_q   <= '0;
            pma_q     <= 1'b1;
            pb_q      <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= {sync_q[0], link.channelUp};
            timer_q   <= timer_d;
            low_run_q <= low_run_d;
            retry_q   <= retry_d;
            pma_q     <= state_d == IDLE || state_d == PMA;
            pb_q      <= state_d inside {IDLE, PMA, PB};
            ready_q   <= state_d == UP;
        end
    end
    assign link.state      = state_q;
    assign link.pmaInit    = pma_q;
    assign link.resetPb    = pb_q;
    assign link.linkReady  = ready_q;
    assign link.retryCount = retry_q;
`ifdef AURORA_SEQ_STATS_EN
    logic [15:0] drop_q;
    logic [31:0] up_q;
    logic drop;
    // leaving UP for PMA without a force request can only be a filtered drop
    assign drop = state_q == UP && state_d == PMA && !restart;
    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            drop_q <= '0;
            up_q   <= '0;
        end else begin
            if (drop && drop_q != 16'hFFFF)
                drop_q <= drop_q + 16'd1;
            if (state_d == UP && state_q != UP)
                up_q <= '0;
            else if (state_q == UP && up_q != 32'hFFFF_FFFF)
                up_q <= up_q + 32'd1;
        end
    end
    assign link.dropCount = drop_q;
    assign link.upTime    = up_q;
`else
    assign link.dropCount = '0;
    assign link.upTime    = '0;
`endif
endmodule

// File: tb/tb_aurora_link_sequencer.sv
// tb_aurora_link_sequencer: vector table, latency sequences and randomized run against a phase/elapsed-time model
module tb_aurora_link_sequencer;
    localparam int PMA_N = 8, PB_N = 4, TO_N = 20, DF_N = 3;
`ifdef AURORA_SEQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1, en = 1'b0, fr = 1'b0, cu = 1'b0;
    int tests = 0, fails = 0;
    always #5 clk = ~clk;
    aurora_link_sequencer_if lif();
    assign lif.enable = en;
    assign lif.forceRestart = fr;
    assign lif.channelUp = cu;
    aurora_link_sequencer #(
        .PMA_INIT_CYCLES(PMA_N), .RESET_PB_HOLD(PB_N), .LINK_TIMEOUT(TO_N), .DROP_FILTER(DF_N), .TIMER_WIDTH(24)
    ) dut (.sysClk(clk), .sysReset(rst), .link(lif));
    // model: phase number, cycles already spent in it, and the two-stage channelUp delay line
    typedef struct packed {
        int ph; int cnt; int low; int rc; int dc; longint ut; bit s1; bit s0;
    } mdl_t;
    mdl_t m = '0;
    function automatic mdl_t next_model(mdl_t c, logic e, logic f, logic u);
        mdl_t n = c;
        bit chs = c.s1;
        bit forced = e && f && c.ph != 0;
        n.s1 = c.s0;
        n.s0 = u;
        if (!e) n.ph = 0;
        else if (forced) n.ph = 1;
        else if (c.ph == 0) n.ph = 1;
        else if (c.ph == 1 && c.cnt + 1 >= PMA_N) n.ph = 2;
        else if (c.ph == 2 && c.cnt + 1 >= PB_N) n.ph = 3;
        else if (c.ph == 3 && chs) n.ph = 4;
        else if (c.ph == 3 && c.cnt + 1 >= TO_N) begin
            n.ph = 1;
            n.rc = c.rc < 255 ? c.rc + 1 : 255;
        end else if (c.ph == 4 && c.low >= DF_N) begin
            n.ph = 1;
            if (STATS) n.dc = c.dc < 65535 ? c.dc + 1 : 65535;
        end
        n.cnt = (n.ph != c.ph || forced) ? 0 : c.cnt + 1;
        n.low = (c.ph == 4 && n.ph == 4 && !chs) ? c.low + 1 : 0;
        if (STATS && c.ph == 4 && c.ut < 64'hFFFF_FFFF) n.ut = c.ut + 1;
        if (n.ph == 4 && c.ph != 4) n.ut = 0;
        return n;
    endfunction
    always @(posedge clk) m <= rst ? '0 : next_model(m, en, fr, cu);
    function automatic logic [63:0] exp_pack(mdl_t c);
        return {2'b0, 3'(c.ph), c.ph <= 1, c.ph <= 2, c.ph == 4, 8'(c.rc), 16'(c.dc), 32'(c.ut)};
    endfunction
    function automatic logic [63:0] dut_pack();
        return {2'b0, lif.state, lif.pmaInit, lif.resetPb, lif.linkReady, lif.retryCount, lif.dropCount, lif.upTime};
    endfunction
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    typedef struct {
        logic rst, en, fr, cu; int n; logic [2:0] st; logic pma, pb, rdy; logic [7:0] rc;
    } vec_t;
    vec_t v[$];
    task automatic add(input logic r, e, f, c, input int n, input logic [2:0] s, input logic pm, b, rd,
                       input logic [7:0] rc);
        vec_t x;
        x.rst = r; x.en = e; x.fr = f; x.cu = c; x.n = n;
        x.st = s; x.pma = pm; x.pb = b; x.rdy = rd; x.rc = rc;
        v.push_back(x);
    endtask
    initial begin
        int k;
        bit armed = 1'b0;
        // reset and hold-off, nominal bring-up with channelUp five cycles into WAIT
        add(1, 0, 0, 0, 1, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 3, 0, 1, 1, 0, 0);
        add(0, 1, 0, 0, 1, 1, 1, 1, 0, 0);
        add(0, 1, 0, 0, 7, 1, 1, 1, 0, 0);
        add(0, 1, 0, 0, 1, 2, 0, 1, 0, 0);
        add(0, 1, 0, 0, 3, 2, 0, 1, 0, 0);
        add(0, 1, 0, 0, 1, 3, 0, 0, 0, 0);
        add(0, 1, 0, 0, 4, 3, 0, 0, 0, 0);
        add(0, 1, 0, 1, 2, 3, 0, 0, 0, 0);
        add(0, 1, 0, 1, 1, 4, 0, 0, 1, 0);
        // 2-cycle glitch ignored, 3-cycle drop restarts without touching retryCount
        add(0, 1, 0, 0, 2, 4, 0, 0, 1, 0);
        add(0, 1, 0, 1, 6, 4, 0, 0, 1, 0);
        add(0, 1, 0, 0, 3, 4, 0, 0, 1, 0);
        add(0, 1, 0, 1, 2, 4, 0, 0, 1, 0);
        add(0, 1, 0, 1, 1, 1, 1, 1, 0, 0);
        add(0, 1, 0, 1, 12, 3, 0, 0, 0, 0);
        add(0, 1, 0, 1, 1, 4, 0, 0, 1, 0);
        // forceRestart in UP, then disable beats force in WAIT
        add(0, 1, 1, 1, 1, 1, 1, 1, 0, 0);
        add(0, 1, 0, 0, 12, 3, 0, 0, 0, 0);
        add(0, 0, 1, 0, 1, 0, 1, 1, 0, 0);
        // timeouts: one, then two more loops
        add(0, 1, 0, 0, 1, 1, 1, 1, 0, 0);
        add(0, 1, 0, 0, 12, 3, 0, 0, 0, 0);
        add(0, 1, 0, 0, 19, 3, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 1, 1, 1, 0, 1);
        add(0, 1, 0, 0, 64, 1, 1, 1, 0, 3);
        // reset during PB
        add(0, 1, 0, 0, 9, 2, 0, 1, 0, 3);
        add(1, 1, 0, 0, 1, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 1, 1, 0, 0);
        fork
            forever begin
                @(negedge clk);
                if (armed) chk("model", dut_pack(), exp_pack(m));
            end
        join_none
        step(2);
        armed = 1'b1;
        foreach (v[i]) begin
            rst = v[i].rst; en = v[i].en; fr = v[i].fr; cu = v[i].cu;
            step(1);
            fr = 1'b0;
            if (v[i].n > 1) step(v[i].n - 1);
            chk($sformatf("vec%0d", i),
                {50'b0, lif.state, lif.pmaInit, lif.resetPb, lif.linkReady, lif.retryCount},
                {50'b0, v[i].st, v[i].pma, v[i].pb, v[i].rdy, v[i].rc});
        end
        // channelUp-to-linkReady latency, then drop latency and upTime after 50 UP cycles
        en = 1'b1;
        step(13);
        chk("wait_reached", 64'(lif.state), 64'd3);
        cu = 1'b1;
        k = 0;
        while (k < 10 && !lif.linkReady) begin
            step(1);
            k++;
        end
        chk("up_latency", 64'(k), 64'd3);
        step(44);
        cu = 1'b0;
        k = 0;
        while (k < 20 && lif.linkReady) begin
            step(1);
            k++;
        end
        chk("drop_latency", 64'(k), 64'(DF_N + 3));
        chk("drop_state", 64'(lif.state), 64'd1);
        chk("uptime", 64'(lif.upTime), STATS ? 64'd50 : 64'd0);
        chk("dropcount", 64'(lif.dropCount), STATS ? 64'd1 : 64'd0);
        step(10);
        chk("uptime_hold", 64'(lif.upTime), STATS ? 64'd50 : 64'd0);
        // 300 timeouts saturate retryCount
        en = 1'b0;
        step(1);
        en = 1'b1;
        step(1 + 300 * (PMA_N + PB_N + TO_N));
        chk("retry_sat", {lif.state, lif.retryCount}, {3'd1, 8'd255});
        // randomized run checked by the model
        for (int i = 0; i < 4000; i++) begin
            rst = $urandom % 800 == 0;
            en = $urandom % 100 != 0;
            fr = $urandom % 150 == 0;
            if ($urandom % (cu ? 40 : 25) == 0) cu = ~cu;
            step(1);
        end
        rst = 1'b0;
        armed = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
